// File: rtl/mealy_pattern_det.sv
// Serial Mealy pattern detector with a run-time loadable pattern/length and an overlap mode.
// Define MEALY_PATTERN_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module mealy_pattern_det #(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = 4,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0011_1000),
    parameter int               RST_LEN = 6,
    parameter int               CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              din_vld,
    input  logic              overlap,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pat_val,
    input  logic [LEN_W-1:0]  pat_len,
    output logic              y,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  match_cnt
);

    typedef enum logic {FILL, ARMED} state_t;

    // din supplies the newest bit, so PAT_W-1 stored bits cover the longest window
    localparam int               HW      = PAT_W - 1;
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  fill_q, fill_d;
    logic [HW-1:0]     hist_q, hist_d;
    logic              cfg_err_d;

    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  bit_ok;
    logic              hit;
    logic              load_ok;
    logic              advance;

    assign window  = {hist_q, din};
    assign load_ok = (pat_len >= MIN_LEN) && (pat_len <= MAX_LEN);
    assign advance = din_vld && !pat_load;

    // Bits at or above the active length never block a match
    genvar i;
    generate
        for (i = 0; i < PAT_W; i++) begin : g_cmp
            localparam logic [LEN_W-1:0] IDX = LEN_W'(i);
            assign bit_ok[i] = (IDX >= len_q) || (window[i] == pat_q[i]);
        end
    endgenerate

    assign hit = &bit_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            pat_q   <= RST_PAT;
            len_q   <= LEN_W'(RST_LEN);
            fill_q  <= '0;
            hist_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            cfg_err <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        fill_d    = fill_q;
        hist_d    = hist_q;
        cfg_err_d = 1'b0;
        if (pat_load) begin
            // A load always swallows the din of its cycle, accepted or not
            if (load_ok) begin
                pat_d   = pat_val;
                len_d   = pat_len;
                fill_d  = '0;
                state_d = FILL;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (din_vld) begin
            hist_d = window[HW-1:0];
            if (state_q == FILL) begin
                fill_d = fill_q + LEN_W'(1);
                if (fill_d == len_q - LEN_W'(1))
                    state_d = ARMED;
            end else if (hit && !overlap) begin
                state_d = FILL;
                fill_d  = '0;
            end
        end
    end

    always_comb begin
        y = 1'b0;
        if (!reset && state_q == ARMED && advance && hit)
            y = 1'b1;
    end

`ifdef MEALY_PATTERN_DET_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            match_cnt <= '0;
        else if (y && match_cnt != '1)
            match_cnt <= match_cnt + CNT_W'(1);
    end
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_mealy_pattern_det.sv
// Directed bench for mealy_pattern_det: default 111000 detection, loads, overlap, reset, gaps, counter.
module tb_mealy_pattern_det;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             din;
    logic             din_vld;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_val;
    logic [LEN_W-1:0] pat_len;
    logic             y;
    logic             cfg_err;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;

    mealy_pattern_det #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .din(din), .din_vld(din_vld), .overlap(overlap),
        .pat_load(pat_load), .pat_val(pat_val), .pat_len(pat_len),
        .y(y), .cfg_err(cfg_err), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Expected counter value after n matches since the last reset
    function automatic logic [31:0] ecnt(input int n);
`ifdef MEALY_PATTERN_DET_CNT_EN
        return (n > 3) ? 32'd3 : 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // One cycle: drive at posedge+1, check y at negedge, return at next posedge+1
    task automatic step(input logic d, input logic v, input logic ey, input string tag);
        din = d; din_vld = v;
        @(negedge clk);
        chk(tag, 32'(y), 32'(ey));
        @(posedge clk); #1;
    endtask

    task automatic seq(input string tag, input logic [15:0] bits, input logic [15:0] ys, input int n);
        for (int k = n - 1; k >= 0; k--)
            step(bits[k], 1'b1, ys[k], $sformatf("%s_b%0d", tag, n - k));
    endtask

    task automatic load(input logic [PAT_W-1:0] v, input logic [LEN_W-1:0] l,
                        input logic d, input logic dv, input logic ecfg, input string tag);
        pat_load = 1'b1; pat_val = v; pat_len = l; din = d; din_vld = dv;
        @(negedge clk);
        chk({tag, "_y"}, 32'(y), 32'd0);
        @(posedge clk); #1;
        pat_load = 1'b0; din_vld = 1'b0;
        chk({tag, "_cfg"}, 32'(cfg_err), 32'(ecfg));
    endtask

    initial begin
        reset = 1'b1; din = 1'b1; din_vld = 1'b1; overlap = 1'b0;
        pat_load = 1'b0; pat_val = '0; pat_len = '0;
        @(posedge clk); #1;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_cfg", 32'(cfg_err), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        reset = 1'b0; din_vld = 1'b0;
        step(1'b0, 1'b0, 1'b0, "idle0");

        // Default 111000, non-overlapping
        seq("def", 16'b1110000, 16'b0000010, 7);
        chk("def_cnt", 32'(match_cnt), ecnt(1));

        // Gap of invalid cycles must not disturb the partial match
        load(8'h38, 4'd6, 1'b1, 1'b1, 1'b0, "ld_gap");
        seq("gap_pre", 16'b11100, 16'b00000, 5);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, $sformatf("gap_idle%0d", k));
        step(1'b0, 1'b1, 1'b1, "gap_resume");
        chk("gap_cnt", 32'(match_cnt), ecnt(2));

        // Asynchronous reset mid-pattern
        seq("ar_pre", 16'b11100, 16'b00000, 5);
        din = 1'b0; din_vld = 1'b1;
        #1 reset = 1'b1;
        #1 chk("ar_y_in_rst", 32'(y), 32'd0);
        chk("ar_cnt_clr", 32'(match_cnt), 32'd0);
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, "ar_post0");
        seq("ar_full", 16'b111000, 16'b000001, 6);
        chk("ar_cnt", 32'(match_cnt), ecnt(1));

        // Rejected loads: one-cycle error pulse, detection unaffected
        load(8'h05, 4'd1, 1'b1, 1'b1, 1'b1, "bad1");
        step(1'b0, 1'b0, 1'b0, "bad1_gap");
        chk("bad1_drop", 32'(cfg_err), 32'd0);
        load(8'h05, 4'd9, 1'b0, 1'b1, 1'b1, "bad9");
        step(1'b0, 1'b0, 1'b0, "bad9_gap");
        chk("bad9_drop", 32'(cfg_err), 32'd0);
        seq("bad_det", 16'b111000, 16'b000001, 6);
        chk("bad_cnt", 32'(match_cnt), ecnt(2));

        // Load beats a would-be matching bit while armed
        seq("pri_pre", 16'b11100, 16'b00000, 5);
        load(8'h38, 4'd6, 1'b0, 1'b1, 1'b0, "pri");
        seq("pri_post", 16'b111000, 16'b000001, 6);

        // Pattern 101 with overlap, then without; counter saturation
        reset = 1'b1; #1 reset = 1'b0;
        overlap = 1'b1;
        load(8'h05, 4'd3, 1'b0, 1'b0, 1'b0, "ld101a");
        step(1'b1, 1'b1, 1'b0, "ov1_b1");
        step(1'b0, 1'b1, 1'b0, "ov1_b2");
        step(1'b1, 1'b1, 1'b1, "ov1_b3");
        chk("sat_c1", 32'(match_cnt), ecnt(1));
        step(1'b0, 1'b1, 1'b0, "ov1_b4");
        step(1'b1, 1'b1, 1'b1, "ov1_b5");
        chk("sat_c2", 32'(match_cnt), ecnt(2));
        overlap = 1'b0;
        load(8'h05, 4'd3, 1'b0, 1'b0, 1'b0, "ld101b");
        seq("ov0", 16'b10101, 16'b00100, 5);
        chk("sat_c3", 32'(match_cnt), ecnt(3));
        overlap = 1'b1;
        step(1'b0, 1'b1, 1'b0, "tog_b1");
        step(1'b1, 1'b1, 1'b1, "tog_b2");
        chk("sat_c4", 32'(match_cnt), ecnt(4));
        step(1'b0, 1'b1, 1'b0, "tog_b3");
        step(1'b1, 1'b1, 1'b1, "tog_b4");
        chk("sat_c5", 32'(match_cnt), ecnt(5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
